// File: rtl/uart_frame_rx.sv
// uart_frame_rx: pops bytes from a UART RX FIFO, assembles SYNC/LEN/payload/CHK frames and
// streams the payload of good frames. Define UART_FRAME_TIMEOUT_EN for the inter-byte timeout.
module uart_frame_rx #(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_err,
    output logic [1:0] err_code
);
    // state   | meaning
    // S_HUNT  | discard bytes until SYNC
    // S_LEN   | pop length byte, reject 0 or > MAX_LEN
    // S_DATA  | store payload, accumulate checksum
    // S_CHK   | compare checksum byte
    // S_DRAIN | stream buffered payload, no UART pops

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT < 1) begin : g_param_check
        $error("uart_frame_rx: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]       sum_q, sum_d;
    logic             frame_err_d;
    logic [1:0]       err_code_d;
    logic             pop;
    logic             buf_we;
    logic             tmr_expired;
    logic [7:0]       frame_buf [MAX_LEN];

    assign pop     = !reset && !rx_empty && (state_q != S_DRAIN);
    assign rd_uart = pop;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] tmr_q;
    logic             in_frame;

    assign in_frame    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
    assign tmr_expired = in_frame && !pop && (tmr_q == '0);

    // Down-counter reloads on every pop; terminal count after TIMEOUT idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q <= TMR_LOAD;
        end else if (pop || !in_frame) begin
            tmr_q <= TMR_LOAD;
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end
`else
    assign tmr_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_idx_d  = last_idx_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        sum_d       = sum_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code;
        buf_we      = 1'b0;
        case (state_q)
            S_HUNT: begin
                if (pop && r_data == SYNC) state_d = S_LEN;
            end
            S_LEN: begin
                if (pop) begin
                    if (r_data == 8'd0 || r_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = S_HUNT;
                    end else begin
                        last_idx_d = IDX_W'(r_data - 8'd1);
                        sum_d      = r_data;
                        wr_idx_d   = '0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (pop) begin
                    buf_we   = 1'b1;
                    sum_d    = sum_q + r_data;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == last_idx_q) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (pop) begin
                    if (r_data == sum_q) begin
                        rd_idx_d = '0;
                        state_d  = S_DRAIN;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                        state_d     = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_idx_q == last_idx_q) state_d = S_HUNT;
                end
            end
            default: state_d = S_HUNT;
        endcase
        if (tmr_expired) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
            state_d     = S_HUNT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_HUNT;
            last_idx_q <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            sum_q      <= 8'h00;
            frame_err  <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state_q    <= state_d;
            last_idx_q <= last_idx_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            sum_q      <= sum_d;
            frame_err  <= frame_err_d;
            err_code   <= err_code_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (buf_we) frame_buf[wr_idx_q] <= r_data;
    end

    assign out_valid = (state_q == S_DRAIN);
    assign out_last  = out_valid && (rd_idx_q == last_idx_q);
    assign out_data  = out_valid ? frame_buf[rd_idx_q] : 8'h00;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: scoreboard bench for uart_frame_rx; a frame-level reference model
// predicts payload bytes and error codes from the byte stream fed into the RX FIFO.
module tb_uart_frame_rx;
    localparam int         MAX_LEN = 16;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_err;
    logic [1:0] err_code;

    uart_frame_rx #(.MAX_LEN(MAX_LEN), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];   // model of the UART RX FIFO
    logic [7:0] pend_q[$];   // bytes the reference model has not yet resolved
    logic [8:0] exp_q[$];    // {last, data}
    logic [1:0] err_q[$];
    logic [7:0] bq[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         ready_mode = 0;
    logic       ready_force = 1'b1;
    logic       rd_seen = 1'b0;
    logic       prev_err = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Frame-level reference: resolves every complete frame at the head of pend_q.
    task automatic model_parse();
        int         l;
        logic [7:0] s;
        while (1) begin
            while (pend_q.size() > 0 && pend_q[0] != SYNC) void'(pend_q.pop_front());
            if (pend_q.size() < 2) break;
            l = int'(pend_q[1]);
            if (l == 0 || l > MAX_LEN) begin
                err_q.push_back(2'd1);
                void'(pend_q.pop_front());
                void'(pend_q.pop_front());
                continue;
            end
            if (pend_q.size() < l + 3) break;
            s = pend_q[1];
            for (int i = 0; i < l; i++) s = s + pend_q[2+i];
            if (s == pend_q[l+2]) begin
                for (int i = 0; i < l; i++) exp_q.push_back({1'(i == l - 1), pend_q[2+i]});
            end else begin
                err_q.push_back(2'd2);
            end
            repeat (l + 3) void'(pend_q.pop_front());
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b[$], input int max_gap);
        foreach (b[i]) begin
            fifo_q.push_back(b[i]);
            pend_q.push_back(b[i]);
            model_parse();
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || err_q.size() != 0) && c < budget) begin
            tick();
            c++;
        end
        check("drain_within_budget", {29'd0, fifo_q.size() == 0, exp_q.size() == 0, err_q.size() == 0}, 32'd7);
        repeat (4) tick();
    endtask

    task automatic wait_fifo_empty(input int budget);
        int c = 0;
        while (fifo_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check("fifo_emptied", fifo_q.size(), 0);
    endtask

    // RX FIFO model: pops on the edge where the DUT held rd_uart high.
    initial begin
        rx_empty = 1'b1;
        r_data   = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
            #2;
            rx_empty = (fifo_q.size() == 0);
            r_data   = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
            #2;
            rd_seen = rd_uart;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            #3;
            out_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor: samples just before each active edge and checks against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                if (out_valid) begin
                    check("no_pop_in_drain", {31'd0, rd_uart}, 0);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_out: got data %0h, expected no output", out_data);
                    end else begin
                        check("out_data", {24'd0, out_data}, {24'd0, exp_q[0][7:0]});
                        check("out_last", {31'd0, out_last}, {31'd0, exp_q[0][8]});
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    check("idle_out_zero", {23'd0, out_last, out_data}, 0);
                end
                if (frame_err) begin
                    check("err_single_cycle", {31'd0, prev_err}, 0);
                    if (err_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_err: got code %0d, expected no error", err_code);
                    end else begin
                        check("err_code", {30'd0, err_code}, {30'd0, err_q.pop_front()});
                    end
                end
            end
            prev_err = frame_err;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c;
        int         kind;
        int         len;
        logic [7:0] s;
        logic [7:0] v;

        reset = 1'b1;
        bq = {8'h00};
        send(bq, 0);
        repeat (3) tick();
        check("rst_rd_uart", {31'd0, rd_uart}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_last", {31'd0, out_last}, 0);
        check("rst_out_data", {24'd0, out_data}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_err_code", {30'd0, err_code}, 0);
        reset = 1'b0;
        wait_idle(100);

        bq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send(bq, 0);
        wait_idle(200);

        bq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        send(bq, 0);
        wait_idle(200);

        bq = {8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h7E, 8'h7F, 8'hA5, 8'h00, 8'hA5, 8'h11};
        send(bq, 0);
        wait_idle(200);
        check("err_code_after_bad_len", {30'd0, err_code}, 1);

        // SYNC inside the payload is plain data.
        bq = {8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C};
        send(bq, 1);
        wait_idle(200);

        // Backpressure: second frame must stay in the FIFO while the first drains.
        ready_force = 1'b0;
        bq = {8'hA5, 8'h02, 8'hAA, 8'h55, 8'h01, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        send(bq, 0);
        c = 0;
        while (!out_valid && c < 50) begin
            tick();
            c++;
        end
        check("bp_out_valid", {31'd0, out_valid}, 1);
        repeat (5) tick();
        check("bp_data_held", {24'd0, out_data}, 32'hAA);
        check("bp_fifo_untouched", fifo_q.size(), 4);
        ready_force = 1'b1;
        wait_idle(200);

        bq = {8'hA5, 8'h02, 8'h11};
        send(bq, 0);
        wait_fifo_empty(50);
`ifdef UART_FRAME_TIMEOUT_EN
        pend_q.delete();
        err_q.push_back(2'd3);
        c = 0;
        while (err_q.size() != 0 && c < 300) begin
            tick();
            c++;
        end
        check("timeout_latency", {31'd0, (c >= 95 && c <= 105)}, 1);
        check("timeout_err_code", {30'd0, err_code}, 3);
        bq = {8'hA5, 8'h01, 8'h05, 8'h06};
        send(bq, 0);
        wait_idle(200);
`else
        repeat (300) tick();
        check("stall_no_output", {31'd0, out_valid}, 0);
        bq = {8'h22, 8'h35};
        send(bq, 0);
        wait_idle(200);
`endif

        // Reset in the middle of a frame abandons it.
        bq = {8'hA5, 8'h04, 8'h01, 8'h02};
        send(bq, 0);
        wait_fifo_empty(50);
        repeat (2) tick();
        reset = 1'b1;
        pend_q.delete();
        bq = {8'hA5, 8'h01, 8'h09, 8'h0A};
        send(bq, 0);
        #2;
        check("midrst_rd_uart", {31'd0, rd_uart}, 0);
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_frame_err", {31'd0, frame_err}, 0);
        check("midrst_err_code", {30'd0, err_code}, 0);
        repeat (2) tick();
        check("midrst_fifo_held", fifo_q.size(), 4);
        reset = 1'b0;
        wait_idle(200);

        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            bq.delete();
            if (kind <= 7) begin
                len = $urandom_range(1, MAX_LEN);
                bq.push_back(SYNC);
                bq.push_back(8'(len));
                s = 8'(len);
                for (int i = 0; i < len; i++) begin
                    v = 8'($urandom);
                    bq.push_back(v);
                    s = s + v;
                end
                if (kind >= 6) s = s + 8'($urandom_range(1, 255));
                bq.push_back(s);
            end else if (kind == 8) begin
                bq.push_back(SYNC);
                bq.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
                    v = 8'($urandom);
                    bq.push_back((v == SYNC) ? 8'h00 : v);
                end
            end
            send(bq, 3);
        end
        wait_idle(5000);
        ready_mode = 0;
        repeat (10) tick();
        check("final_exp_empty", exp_q.size(), 0);
        check("final_err_empty", err_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
